// File: rtl/adder_arbiter.sv
// Two-requester front end to one shared adder. Round-robin grant, one operation
// in flight at a time, result held until the consumer takes it.
module adder_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  input  logic             res_ready,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, next_state;
  logic             last_grant;
  logic             grant_id;
  logic             grant_valid;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = CALC;
      CALC:    next_state = DONE;
      DONE:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // On a tie the requester that lost last time wins; a lone requester always wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = (state == DONE);
    if (state == IDLE && grant_valid && !rst) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      res_sum    <= '0;
      res_id     <= 1'b0;
      op_count   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_a       <= grant_id ? req1_a : req0_a;
            op_b       <= grant_id ? req1_b : req0_b;
            op_id      <= grant_id;
            last_grant <= grant_id;
          end
        end
        CALC: begin
          res_sum <= {1'b0, op_a} + {1'b0, op_b};
          res_id  <= op_id;
        end
        DONE: begin
          if (res_ready) op_count <= op_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: arbitration order, sums, stalls, reset
// mid-operation and a long run that wraps the completion counter.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic [16:0] res_sum;
  logic        res_id;
  logic        res_ready;
  logic [7:0]  op_count;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_count = 8'h00;
  logic [15:0] tbl_a [100];
  logic [15:0] tbl_b [100];
  logic [16:0] held_sum;

  adder_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_id(res_id),
    .res_ready(res_ready), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [15:0] a0, input logic [15:0] b0,
                               input logic [15:0] a1, input logic [15:0] b1,
                               input logic rr);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    res_ready = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue from IDLE, scramble the ports after the grant, and consume the result.
  task automatic txn(input logic v0, input logic v1,
                     input logic [15:0] a0, input logic [15:0] b0,
                     input logic [15:0] a1, input logic [15:0] b1,
                     input logic exp_id, input logic [16:0] exp_sum);
    applyStimulus(v0, v1, a0, b0, a1, b1, 1'b1);
    checkOutput("grant_ready0", {31'd0, req0_ready}, {31'd0, !exp_id});
    checkOutput("grant_ready1", {31'd0, req1_ready}, {31'd0, exp_id});
    tick();
    applyStimulus(v0, v1, ~a0, ~b0, ~a1, ~b1, 1'b1);
    checkOutput("calc_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("calc_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    tick();
    #1;
    checkOutput("done_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("done_sum", {15'd0, res_sum}, {15'd0, exp_sum});
    checkOutput("done_id", {31'd0, res_id}, {31'd0, exp_id});
    checkOutput("done_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    tick();
    exp_count = exp_count + 8'd1;
    checkOutput("op_count", {24'd0, op_count}, {24'd0, exp_count});
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_sum", {15'd0, res_sum}, 32'd0);
    checkOutput("rst_id", {31'd0, res_id}, 32'd0);
    checkOutput("rst_count", {24'd0, op_count}, 32'd0);
    checkOutput("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    rst = 1'b0;
    #1;

    $display("[TB] round-robin with both requesters valid");
    txn(1'b1, 1'b1, 16'h0010, 16'h0001, 16'h0020, 16'h0002, 1'b0, 17'h00011);
    txn(1'b1, 1'b1, 16'h0010, 16'h0001, 16'h0020, 16'h0002, 1'b1, 17'h00022);
    txn(1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 1'b0, 17'h00200);
    txn(1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 1'b1, 17'h00400);

    $display("[TB] single requesters and carry cases");
    txn(1'b1, 1'b0, 16'h1234, 16'h0FED, 16'h5555, 16'h5555, 1'b0, 17'h02221);
    txn(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE);
    txn(1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 17'h10000);
    txn(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0007, 16'h0008, 1'b1, 17'h0000F);
    txn(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0009, 16'h0001, 1'b1, 17'h0000A);
    txn(1'b1, 1'b1, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 1'b0, 17'h00007);

    $display("[TB] consumer stall in DONE");
    applyStimulus(1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    checkOutput("stall_grant1", {31'd0, req1_ready}, 32'd1);
    tick();
    tick();
    #1;
    held_sum = 17'h07777;
    checkOutput("stall_sum0", {15'd0, res_sum}, {15'd0, held_sum});
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("stall_sum", {15'd0, res_sum}, {15'd0, held_sum});
      checkOutput("stall_id", {31'd0, res_id}, 32'd1);
      checkOutput("stall_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      checkOutput("stall_count", {24'd0, op_count}, {24'd0, exp_count});
    end
    res_ready = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
    checkOutput("stall_release_count", {24'd0, op_count}, {24'd0, exp_count});
    txn(1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 17'h03333);

    $display("[TB] reset during CALC");
    applyStimulus(1'b1, 1'b0, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    exp_count = 8'h00;
    checkOutput("midrst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("midrst_count", {24'd0, op_count}, 32'd0);
    checkOutput("midrst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    tick();
    rst = 1'b0;
    txn(1'b1, 1'b0, 16'h0101, 16'h0202, 16'h0000, 16'h0000, 1'b0, 17'h00303);

    $display("[TB] long run through operand table");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 8'h00;
    for (int i = 0; i < 100; i++) begin
      tbl_a[i] = 16'($urandom);
      tbl_b[i] = 16'($urandom);
    end
    tbl_a[0] = 16'hFFFF; tbl_b[0] = 16'hFFFF;
    tbl_a[1] = 16'h0000; tbl_b[1] = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0)
        txn(1'b1, 1'b0, tbl_a[i % 100], tbl_b[i % 100], 16'h0000, 16'h0000,
            1'b0, {1'b0, tbl_a[i % 100]} + {1'b0, tbl_b[i % 100]});
      else
        txn(1'b0, 1'b1, 16'h0000, 16'h0000, tbl_a[i % 100], tbl_b[i % 100],
            1'b1, {1'b0, tbl_a[i % 100]} + {1'b0, tbl_b[i % 100]});
    end
    checkOutput("wrap_count", {24'd0, op_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
